// File: rtl/cpu_mem_arb_pkg.sv
// Shared types and constants for the CPU memory arbiter.
//   arb_state_e : arbiter FSM state encoding
//   SRC_IF/DM   : requester identifiers driven on m_req_src / bus_err_src
//   NOP_INSTR   : instruction substituted for a failed or timed-out fetch
package cpu_mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_DM = 3'd1,
    ST_WAIT_DM  = 3'd2,
    ST_ISSUE_IF = 3'd3,
    ST_WAIT_IF  = 3'd4,
    ST_RELEASE  = 3'd5
  } arb_state_e;

  localparam logic        SRC_IF    = 1'b0;
  localparam logic        SRC_DM    = 1'b1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_req_timer.sv
// Response timeout counter for one outstanding downstream access.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : zero the count (asserted on the request handshake)
//   en       : count one cycle (asserted while waiting for the response)
//   expire   : count has reached TIMEOUT_CYC-1; never asserted when TIMEOUT_CYC == 0
module mem_req_timer #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (TIMEOUT_CYC != 0) && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates one downstream memory port between instruction fetch (IF) and
// the MEM-stage data port (DM). DM is served first, then IF; the pipeline is
// stalled until every access of the current step has completed.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | sample requests and operands, stall follows live requests
// ST_ISSUE_DM| present the latched DM request until m_req_ready
// ST_WAIT_DM | wait for DM response or timeout
// ST_ISSUE_IF| present the latched IF request until m_req_ready
// ST_WAIT_IF | wait for IF response or timeout
// ST_RELEASE | one cycle with both stalls low so the pipeline advances
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   if_req/if_addr             fetch request;  if_rdata, im_stall back
//   dm_rd/dm_wr/dm_addr/...    data request;   dm_rdata, dm_stall back
//   m_req_*                    downstream request channel (valid/ready)
//   m_rsp_*                    downstream response (single-cycle pulse)
//   bus_err, bus_err_src       error/timeout pulse and its source
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                im_stall,
  input  logic                dm_rd,
  input  logic                dm_wr,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W-1:0]   dm_bweb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_stall,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_we,
  output logic [DATA_W/8-1:0] m_req_wstrb,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic                m_req_src,
  input  logic                m_rsp_valid,
  input  logic [DATA_W-1:0]   m_rsp_rdata,
  input  logic                m_rsp_err,
  output logic                bus_err,
  output logic                bus_err_src
);

  localparam int NB = DATA_W / 8;

  arb_state_e state_q, state_d;

  logic              pend_dm_q, pend_if_q, dm_we_q;
  logic [ADDR_W-1:0] if_addr_q, dm_addr_q;
  logic [DATA_W-1:0] dm_wdata_q, dm_bweb_q;
  logic [NB-1:0]     dm_strb;
  logic              tmo_expire, in_wait, rsp_done, rsp_bad;

  always_comb begin
    dm_strb = '0;
    for (int i = 0; i < NB; i++) begin
      dm_strb[i] = ~&dm_bweb_q[8*i +: 8];
    end
  end

  assign in_wait = (state_q == ST_WAIT_DM) || (state_q == ST_WAIT_IF);
  // A missing response at completion means the timer expired.
  assign rsp_bad = !m_rsp_valid || m_rsp_err;

  mem_req_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (m_req_valid && m_req_ready),
    .en     (in_wait),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pend_dm_q  <= 1'b0;
      pend_if_q  <= 1'b0;
      dm_we_q    <= 1'b0;
      if_addr_q  <= '0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_bweb_q  <= '1;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        pend_dm_q  <= dm_rd | dm_wr;
        pend_if_q  <= if_req;
        dm_we_q    <= dm_wr;
        if_addr_q  <= if_addr;
        dm_addr_q  <= dm_addr;
        dm_wdata_q <= dm_wdata;
        dm_bweb_q  <= dm_bweb;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    m_req_valid = 1'b0;
    m_req_addr  = '0;
    m_req_we    = 1'b0;
    m_req_wstrb = '0;
    m_req_wdata = '0;
    m_req_src   = SRC_IF;
    im_stall    = 1'b0;
    dm_stall    = 1'b0;
    rsp_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        im_stall = if_req | dm_rd | dm_wr;
        dm_stall = if_req | dm_rd | dm_wr;
        if (dm_rd | dm_wr)  state_d = ST_ISSUE_DM;
        else if (if_req)    state_d = ST_ISSUE_IF;
      end
      ST_ISSUE_DM: begin
        im_stall    = pend_if_q;
        dm_stall    = pend_dm_q;
        m_req_valid = 1'b1;
        m_req_addr  = dm_addr_q;
        m_req_we    = dm_we_q;
        m_req_wstrb = dm_we_q ? dm_strb : '0;
        m_req_wdata = dm_wdata_q;
        m_req_src   = SRC_DM;
        if (m_req_ready) state_d = ST_WAIT_DM;
      end
      ST_WAIT_DM: begin
        im_stall = pend_if_q;
        dm_stall = pend_dm_q;
        if (m_rsp_valid || tmo_expire) begin
          rsp_done = 1'b1;
          state_d  = pend_if_q ? ST_ISSUE_IF : ST_RELEASE;
        end
      end
      ST_ISSUE_IF: begin
        im_stall    = pend_if_q;
        dm_stall    = pend_dm_q;
        m_req_valid = 1'b1;
        m_req_addr  = if_addr_q;
        m_req_src   = SRC_IF;
        if (m_req_ready) state_d = ST_WAIT_IF;
      end
      ST_WAIT_IF: begin
        im_stall = pend_if_q;
        dm_stall = pend_dm_q;
        if (m_rsp_valid || tmo_expire) begin
          rsp_done = 1'b1;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata    <= DATA_W'(NOP_INSTR);
      dm_rdata    <= '0;
      bus_err     <= 1'b0;
      bus_err_src <= SRC_IF;
    end else begin
      bus_err <= 1'b0;
      if (rsp_done) begin
        if (state_q == ST_WAIT_DM) begin
          if (!dm_we_q) dm_rdata <= rsp_bad ? '0 : m_rsp_rdata;
        end else begin
          if_rdata <= rsp_bad ? DATA_W'(NOP_INSTR) : m_rsp_rdata;
        end
        if (rsp_bad) begin
          bus_err     <= 1'b1;
          bus_err_src <= (state_q == ST_WAIT_DM) ? SRC_DM : SRC_IF;
        end
      end
    end
  end

endmodule
